rom_rd_arbiter: RTL and testbench

//  Shares one 1R0W latch-based ROM macro (2048x16, ren/addr latched on clock-low, data held in SDL) among NREQ requesters.
//  - Arbitration: round-robin, one read per cycle, fixed 2-cycle read latency.
//  - Power: sequences the ROM power-enable chain; ROM is off while idle, woken on demand.
//  - Sits between the ROM macro and its client blocks, e.g. the microcode and table-lookup engines.

---
 rtl/rom_arb_pkg.sv | 40 ++++
 rtl/rom_rd_arbiter_if.sv | 34 +++
 rtl/rom_arb_rr.sv | 31 +++
 rtl/rom_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rom_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types, constants and the round-robin pick function
// for the ROM read arbiter.
//   pwr_state_e : power sequencing FSM states (OFF, WAKE, ON)
//   RD_LAT      : grant-to-read-data latency in cycles
//   MAX_REQ     : upper bound on requester count supported by rr_pick
//   rr_pick     : one-hot round-robin winner from a request vector and pointer
package rom_arb_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2
    } pwr_state_e;

    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned MAX_REQ = 8;

    // Scans from ptr upward, wrapping modulo nreq; first set request wins.
    // Vectors are sized for MAX_REQ; bits at or above nreq are ignored.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [2:0]         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 3'((32'(ptr) + k) % nreq);
            if (k < nreq && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// rom_rd_arbiter_if: client-side read bus of the ROM arbiter.
//   ireq     : per-requester read request, held until granted
//   iaddr    : per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//   ogrant   : one-hot accept strobe
//   ordvalid : one-hot read-data valid
//   ordata   : read data qualified by ordvalid
// master = requester side, slave = arbiter side.
interface rom_rd_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
);
    logic [NREQ-1:0]        ireq;
    logic [NREQ*ADDR_W-1:0] iaddr;
    logic [NREQ-1:0]        ogrant;
    logic [NREQ-1:0]        ordvalid;
    logic [DATA_W-1:0]      ordata;

    modport master (
        output ireq,
        output iaddr,
        input  ogrant,
        input  ordvalid,
        input  ordata
    );

    modport slave (
        input  ireq,
        input  iaddr,
        output ogrant,
        output ordvalid,
        output ordata
    );
endinterface

// File: rtl/rom_arb_rr.sv
// rom_arb_rr: purely combinational round-robin picker.
//   ireq    : request vector
//   iptr    : round-robin pointer (highest-priority index)
//   owinner : one-hot winner (zero when no request)
//   oidx    : binary index of the winner (zero when no request)
module rom_arb_rr
    import rom_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  ireq,
    input  logic [PTR_W-1:0] iptr,
    output logic [NREQ-1:0]  owinner,
    output logic [2:0]       oidx
);

    logic [MAX_REQ-1:0] pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(ireq), 3'(iptr), NREQ);
        owinner = pick[NREQ-1:0];
        oidx    = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) begin
                oidx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter: shares one 1R0W latch-based ROM macro among NREQ requesters.
// Round-robin, one read per cycle, grant-to-ordvalid latency of 2 cycles.
// The ROM is powered down while idle and woken on demand.
//   ickr           : clock (also drives the ROM clock)
//   irstb          : async active-low reset
//   bus            : client read bus (ireq/iaddr in, ogrant/ordvalid/ordata out)
//   iforce_on      : 1 = suppress idle power-down
//   orom_ren       : ROM read enable (flopped)
//   orom_addr      : ROM address (flopped, holds when not reading)
//   irom_dout      : ROM read data
//   orom_pwreninb  : ROM power enable, 0 = powered
//   irom_pwrenoutb : ROM power chain settled when 0
//   opwr_on        : power FSM is in ON
module rom_rd_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAKE_MIN = 4,
    parameter int unsigned IDLE_TO  = 64
) (
    input  logic                ickr,
    input  logic                irstb,
    rom_rd_arbiter_if.slave     bus,
    input  logic                iforce_on,
    output logic                orom_ren,
    output logic [ADDR_W-1:0]   orom_addr,
    input  logic [DATA_W-1:0]   irom_dout,
    output logic                orom_pwreninb,
    input  logic                irom_pwrenoutb,
    output logic                opwr_on
);

    localparam int unsigned PTR_W  = $clog2(NREQ);
    localparam int unsigned WCNT_W = (WAKE_MIN > 1) ? $clog2(WAKE_MIN) : 1;
    localparam int unsigned ICNT_W = $clog2(IDLE_TO);
    localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_MIN - 1);
    localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'(IDLE_TO - 1);

    pwr_state_e          state;
    logic [WCNT_W-1:0]   wake_cnt;
    logic [ICNT_W-1:0]   idle_cnt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [NREQ-1:0]     winner;
    logic [2:0]          win_idx;
    logic [NREQ-1:0]     grant;
    logic [ADDR_W-1:0]   win_addr;
    logic                in_flight;
    logic [DATA_W-1:0]   rd_data;
    // Winner one-hot per pipeline stage; the last stage is ordvalid itself.
    logic [NREQ-1:0]     tag_q [RD_LAT];

    rom_arb_rr #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .ireq    (bus.ireq),
        .iptr    (rr_ptr),
        .owinner (winner),
        .oidx    (win_idx)
    );

    assign grant        = (state == ON) ? winner : '0;
    assign ptr_next     = PTR_W'((32'(win_idx) + 1) % NREQ);
    assign bus.ogrant   = grant;
    assign bus.ordvalid = tag_q[RD_LAT-1];
    assign bus.ordata   = rd_data;

    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                win_addr = bus.iaddr[i*ADDR_W +: ADDR_W];
            end
        end
        // A read is in flight from issue until the stage feeding ordvalid empties.
        in_flight = 1'b0;
        for (int unsigned s = 0; s < RD_LAT - 1; s++) begin
            in_flight = in_flight | (|tag_q[s]);
        end
    end

    // Power sequencing FSM with wake and idle counters.
    always_ff @(posedge ickr or negedge irstb) begin
        if (!irstb) begin
            state         <= OFF;
            wake_cnt      <= '0;
            idle_cnt      <= '0;
            orom_pwreninb <= 1'b1;
            opwr_on       <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (|bus.ireq) begin
                        state         <= WAKE;
                        wake_cnt      <= '0;
                        orom_pwreninb <= 1'b0;
                    end
                end
                WAKE: begin
                    if (wake_cnt >= WAKE_LAST && !irom_pwrenoutb) begin
                        state    <= ON;
                        opwr_on  <= 1'b1;
                        idle_cnt <= '0;
                    end else if (wake_cnt < WAKE_LAST) begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                ON: begin
                    // A request in the terminal idle cycle is checked first, so it
                    // keeps the ROM on and is granted in that same cycle.
                    if ((|bus.ireq) || in_flight) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        if (!iforce_on) begin
                            state         <= OFF;
                            orom_pwreninb <= 1'b1;
                            opwr_on       <= 1'b0;
                            idle_cnt      <= '0;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= OFF;
                    orom_pwreninb <= 1'b1;
                    opwr_on       <= 1'b0;
                end
            endcase
        end
    end

    // Issue flops, round-robin pointer and read-return tag pipeline.
    always_ff @(posedge ickr or negedge irstb) begin
        if (!irstb) begin
            rr_ptr    <= '0;
            orom_ren  <= 1'b0;
            orom_addr <= '0;
            rd_data   <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            orom_ren <= |grant;
            if (|grant) begin
                orom_addr <= win_addr;
                rr_ptr    <= ptr_next;
            end
            tag_q[0] <= grant;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            // Capture only when a read returns so ordata stays quiet otherwise.
            if (|tag_q[RD_LAT-2]) begin
                rd_data <= irom_dout;
            end
        end
    end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter: directed self-checking bench for rom_rd_arbiter with a
// behavioural ROM (latches ren/addr on the low phase) and power-chain model.
module tb_rom_rd_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PWR_DLY = 6;

    logic               ickr;
    logic               irstb;
    logic               iforce_on;
    logic               orom_ren;
    logic [ADDR_W-1:0]  orom_addr;
    logic [DATA_W-1:0]  irom_dout;
    logic               orom_pwreninb;
    logic               irom_pwrenoutb;
    logic               opwr_on;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned pcnt;
    int unsigned n;

    rom_rd_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_rd_arbiter #(
        .NREQ     (NREQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAKE_MIN (4),
        .IDLE_TO  (64)
    ) dut (
        .ickr           (ickr),
        .irstb          (irstb),
        .bus            (bus),
        .iforce_on      (iforce_on),
        .orom_ren       (orom_ren),
        .orom_addr      (orom_addr),
        .irom_dout      (irom_dout),
        .orom_pwreninb  (orom_pwreninb),
        .irom_pwrenoutb (irom_pwrenoutb),
        .opwr_on        (opwr_on)
    );

    function automatic logic [15:0] rom_val(input logic [10:0] a);
        return {a[2:0], a[10:3], a[4:0]} ^ 16'hA5C3;
    endfunction

    initial ickr = 1'b0;
    always #5 ickr = ~ickr;

    // ROM and power-chain models act on the low phase.
    initial begin
        irom_dout      = '0;
        irom_pwrenoutb = 1'b1;
        pcnt           = 0;
    end

    always @(negedge ickr) begin
        if (orom_ren === 1'b1) irom_dout = rom_val(orom_addr);
        if (orom_pwreninb !== 1'b0) begin
            pcnt           = 0;
            irom_pwrenoutb = 1'b1;
        end else begin
            if (pcnt < 255) pcnt++;
            irom_pwrenoutb = (pcnt >= PWR_DLY) ? 1'b0 : 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge ickr);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  exp_g  [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
    logic [3:0]  exp_v  [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    int unsigned exp_vi [7] = '{0, 0, 0, 1, 2, 3, 0};
    logic [10:0] t2_addr [4] = '{11'h015, 11'h2A4, 11'h555, 11'h6C3};

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        irstb     = 1'b0;
        iforce_on = 1'b0;
        bus.ireq  = '0;
        bus.iaddr = '0;

        // Reset values
        tick();
        tick();
        check("rst_grant",    32'(bus.ogrant),   32'h0);
        check("rst_rdvalid",  32'(bus.ordvalid), 32'h0);
        check("rst_rdata",    32'(bus.ordata),   32'h0);
        check("rst_ren",      32'(orom_ren),     32'h0);
        check("rst_addr",     32'(orom_addr),    32'h0);
        check("rst_pwreninb", 32'(orom_pwreninb), 32'h1);
        check("rst_pwr_on",   32'(opwr_on),      32'h0);

        // Test 1: wake on demand, then grant and read of requester 1
        irstb = 1'b1;
        bus.ireq = 4'b0010;
        bus.iaddr[1*ADDR_W +: ADDR_W] = 11'h123;
        #1;
        check("off_no_grant", 32'(bus.ogrant), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("wake_pwreninb", 32'(orom_pwreninb), 32'h0);
            check("wake_no_grant", 32'(bus.ogrant), 32'h0);
            check("wake_pwr_on",   32'(opwr_on), 32'h0);
        end
        tick();
        check("t1_pwr_on", 32'(opwr_on), 32'h1);
        check("t1_grant",  32'(bus.ogrant), 32'h2);
        tick();
        bus.ireq = '0;
        #1;
        check("t1_ren",     32'(orom_ren), 32'h1);
        check("t1_addr",    32'(orom_addr), 32'h123);
        check("t1_rdvalid0", 32'(bus.ordvalid), 32'h0);
        tick();
        check("t1_rdvalid", 32'(bus.ordvalid), 32'h2);
        check("t1_rdata",   32'(bus.ordata), 32'(rom_val(11'h123)));

        // Test 6: 0x000 then 0x7FF back-to-back (requesters 2 then 3)
        bus.ireq = 4'b1100;
        bus.iaddr[2*ADDR_W +: ADDR_W] = 11'h000;
        bus.iaddr[3*ADDR_W +: ADDR_W] = 11'h7FF;
        #1;
        check("t6_grant_a", 32'(bus.ogrant), 32'h4);
        tick();
        bus.ireq = 4'b1000;
        #1;
        check("t6_grant_b", 32'(bus.ogrant), 32'h8);
        check("t6_addr_a",  32'(orom_addr), 32'h000);
        check("t6_rdvalid0", 32'(bus.ordvalid), 32'h0);
        tick();
        bus.ireq = '0;
        #1;
        check("t6_addr_b",    32'(orom_addr), 32'h7FF);
        check("t6_rdvalid_a", 32'(bus.ordvalid), 32'h4);
        check("t6_rdata_a",   32'(bus.ordata), 32'(rom_val(11'h000)));
        tick();
        check("t6_rdvalid_b", 32'(bus.ordvalid), 32'h8);
        check("t6_rdata_b",   32'(bus.ordata), 32'(rom_val(11'h7FF)));
        tick();

        // Test 2: all four requesting, pointer at 0
        for (int unsigned i = 0; i < 4; i++) begin
            bus.iaddr[i*ADDR_W +: ADDR_W] = t2_addr[i];
        end
        bus.ireq = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            if (k == 5) bus.ireq = '0;
            #1;
            check("t2_grant",   32'(bus.ogrant), 32'(exp_g[k]));
            check("t2_rdvalid", 32'(bus.ordvalid), 32'(exp_v[k]));
            if (exp_v[k] != 4'h0) begin
                check("t2_rdata", 32'(bus.ordata), 32'(rom_val(t2_addr[exp_vi[k]])));
            end
        end

        // Test 3: last read issued two cycles ago; first idle cycle is now
        repeat (63) tick();
        check("t3_pwreninb_term", 32'(orom_pwreninb), 32'h0);
        check("t3_pwr_on_term",   32'(opwr_on), 32'h1);
        tick();
        check("t3_pwreninb_off", 32'(orom_pwreninb), 32'h1);
        check("t3_pwr_on_off",   32'(opwr_on), 32'h0);

        // Test 3b: force_on keeps the ROM powered through a long idle stretch
        iforce_on = 1'b1;
        bus.ireq = 4'b0001;
        bus.iaddr[0*ADDR_W +: ADDR_W] = 11'h0AA;
        #1;
        n = 0;
        while (bus.ogrant == '0 && n < 20) begin
            tick();
            n++;
        end
        check("t3b_wake_cycles", 32'(n), 32'd7);
        check("t3b_grant", 32'(bus.ogrant), 32'h1);
        tick();
        bus.ireq = '0;
        tick();
        check("t3b_rdvalid", 32'(bus.ordvalid), 32'h1);
        check("t3b_rdata",   32'(bus.ordata), 32'(rom_val(11'h0AA)));
        repeat (98) tick();
        check("t3b_pwreninb", 32'(orom_pwreninb), 32'h0);
        check("t3b_pwr_on",   32'(opwr_on), 32'h1);

        // Test 4a: force released together with a request in the terminal cycle
        iforce_on = 1'b0;
        bus.ireq = 4'b0100;
        bus.iaddr[2*ADDR_W +: ADDR_W] = 11'h3C5;
        #1;
        check("t4a_grant", 32'(bus.ogrant), 32'h4);
        tick();
        bus.ireq = '0;
        #1;
        check("t4a_ren",    32'(orom_ren), 32'h1);
        check("t4a_pwr_on", 32'(opwr_on), 32'h1);

        // Test 4: request for requester 2 arrives in the terminal idle cycle
        repeat (64) tick();
        check("t4_pwreninb_term", 32'(orom_pwreninb), 32'h0);
        bus.ireq = 4'b0100;
        bus.iaddr[2*ADDR_W +: ADDR_W] = 11'h1E1;
        #1;
        check("t4_grant", 32'(bus.ogrant), 32'h4);
        tick();
        bus.ireq = '0;
        #1;
        check("t4_pwreninb", 32'(orom_pwreninb), 32'h0);
        check("t4_pwr_on",   32'(opwr_on), 32'h1);
        check("t4_ren",      32'(orom_ren), 32'h1);
        check("t4_addr",     32'(orom_addr), 32'h1E1);

        // Test 5: reset between grant and ordvalid
        irstb = 1'b0;
        #1;
        check("t5_rdvalid",  32'(bus.ordvalid), 32'h0);
        check("t5_rdata",    32'(bus.ordata), 32'h0);
        check("t5_ren",      32'(orom_ren), 32'h0);
        check("t5_addr",     32'(orom_addr), 32'h0);
        check("t5_pwreninb", 32'(orom_pwreninb), 32'h1);
        check("t5_pwr_on",   32'(opwr_on), 32'h0);
        check("t5_grant",    32'(bus.ogrant), 32'h0);
        #2;
        irstb = 1'b1;
        tick();
        check("t5_rdvalid_a", 32'(bus.ordvalid), 32'h0);
        check("t5_rdata_a",   32'(bus.ordata), 32'h0);
        tick();
        check("t5_rdvalid_b",  32'(bus.ordvalid), 32'h0);
        check("t5_pwreninb_b", 32'(orom_pwreninb), 32'h1);
        check("t5_pwr_on_b",   32'(opwr_on), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
